// File: rtl/prga_stream_if.sv
// prga_stream_if
// Bundles the start handshake and the three memory ports of the RC4
// pseudo-random generation stage.
//   en / rdy                      start request and idle indication
//   s_addr/s_rddata/s_wrdata/s_wren   state array (s_mem) port
//   ct_addr/ct_rddata             ciphertext memory (read-only) port
//   pt_addr/pt_wrdata/pt_wren     plaintext memory (write-only) port
// master: the generation stage itself. slave: the memories and the caller.
interface prga_stream_if;
    logic       en;
    logic       rdy;
    logic [7:0] s_addr;
    logic [7:0] s_rddata;
    logic [7:0] s_wrdata;
    logic       s_wren;
    logic [7:0] ct_addr;
    logic [7:0] ct_rddata;
    logic [7:0] pt_addr;
    logic [7:0] pt_wrdata;
    logic       pt_wren;

    modport master (
        input  en, s_rddata, ct_rddata,
        output rdy, s_addr, s_wrdata, s_wren, ct_addr, pt_addr, pt_wrdata, pt_wren
    );

    modport slave (
        output en, s_rddata, ct_rddata,
        input  rdy, s_addr, s_wrdata, s_wren, ct_addr, pt_addr, pt_wrdata, pt_wren
    );
endinterface

// File: rtl/prga_stream.sv
// prga_stream
// RC4 pseudo-random generation stage. Reads the length-prefixed ciphertext
// from ct_mem, keeps permuting s_mem to produce one keystream byte per
// message byte, and writes the length-prefixed plaintext into pt_mem.
// All memories are single-port with one cycle of read latency.
// Ports:
//   clk  system clock, rising edge
//   rst  asynchronous active-high reset
//   bus  prga_stream_if.master: en/rdy handshake, s/ct/pt memory ports
module prga_stream (
    input  logic           clk,
    input  logic           rst,
    prga_stream_if.master  bus
);

    typedef enum logic [3:0] {
        IDLE,
        RD_LEN,
        WR_LEN,
        S_I,
        S_J,
        SWAP_I,
        SWAP_J,
        RD_PAD,
        WR_PT
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] i_q,   i_d;
    logic [7:0] j_q,   j_d;
    logic [7:0] k_q,   k_d;
    logic [7:0] len_q, len_d;
    logic [7:0] si_q,  si_d;
    logic [7:0] sj_q,  sj_d;
    logic [7:0] ctb_q, ctb_d;

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state registers use non-blocking assignments so every register
        // samples the pre-edge values of the others.
        if (rst) begin
            state_q <= IDLE;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            len_q   <= '0;
            si_q    <= '0;
            sj_q    <= '0;
            ctb_q   <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            len_q   <= len_d;
            si_q    <= si_d;
            sj_q    <= sj_d;
            ctb_q   <= ctb_d;
        end
    end

    assign bus.rdy = (state_q == IDLE);

    always_comb begin
        // NOTE: every output and next-state value gets a default first, so no
        // path through the case statement can infer a latch.
        state_d       = state_q;
        i_d           = i_q;
        j_d           = j_q;
        k_d           = k_q;
        len_d         = len_q;
        si_d          = si_q;
        sj_d          = sj_q;
        ctb_d         = ctb_q;
        bus.s_addr    = '0;
        bus.s_wrdata  = '0;
        bus.s_wren    = 1'b0;
        bus.ct_addr   = '0;
        bus.pt_addr   = '0;
        bus.pt_wrdata = '0;
        bus.pt_wren   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.en) state_d = RD_LEN;
            end
            RD_LEN: begin
                bus.ct_addr = 8'd0;
                state_d     = WR_LEN;
            end
            WR_LEN: begin
                // Length byte is copied straight through to pt[0].
                len_d         = bus.ct_rddata;
                bus.pt_addr   = 8'd0;
                bus.pt_wrdata = bus.ct_rddata;
                bus.pt_wren   = 1'b1;
                i_d           = 8'd0;
                j_d           = 8'd0;
                k_d           = 8'd1;
                state_d       = (bus.ct_rddata == 8'd0) ? IDLE : S_I;
            end
            S_I: begin
                // Fetch s[i+1] and the ciphertext byte in the same cycle.
                bus.s_addr  = i_q + 8'd1;
                bus.ct_addr = k_q;
                i_d         = i_q + 8'd1;
                state_d     = S_J;
            end
            S_J: begin
                si_d       = bus.s_rddata;
                ctb_d      = bus.ct_rddata;
                bus.s_addr = j_q + bus.s_rddata;
                j_d        = j_q + bus.s_rddata;
                state_d    = SWAP_I;
            end
            SWAP_I: begin
                // s[j] arrives this cycle and is written straight into s[i].
                sj_d         = bus.s_rddata;
                bus.s_addr   = i_q;
                bus.s_wrdata = bus.s_rddata;
                bus.s_wren   = 1'b1;
                state_d      = SWAP_J;
            end
            SWAP_J: begin
                // When i == j this rewrites the original value, as RC4 requires.
                bus.s_addr   = j_q;
                bus.s_wrdata = si_q;
                bus.s_wren   = 1'b1;
                state_d      = RD_PAD;
            end
            RD_PAD: begin
                // Issued after both swap writes, so it sees the permuted array.
                bus.s_addr = si_q + sj_q;
                state_d    = WR_PT;
            end
            WR_PT: begin
                bus.pt_addr   = k_q;
                bus.pt_wrdata = bus.s_rddata ^ ctb_q;
                bus.pt_wren   = 1'b1;
                // Compare before incrementing so L=255 ends without k wrapping.
                if (k_q == len_q) begin
                    state_d = IDLE;
                end else begin
                    k_d     = k_q + 8'd1;
                    state_d = S_I;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
